// File: rtl/countdown_timer.sv
// Millisecond countdown timer: loads a saturated preset, decrements once per
// divided tick while running, pauses/resumes on start_stop rises, flags expiry.
module countdown_timer #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int TICK_HZ     = 1000,
  parameter int MAX_COUNT   = 9999,
  localparam int CW         = $clog2(MAX_COUNT + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [CW-1:0] preset_in,
  input  logic          load,
  input  logic          start_stop,
  output logic [CW-1:0] remaining,
  output logic          running,
  output logic          expired,
  output logic          expired_pulse
);

  localparam int DIV = CLK_FREQ_HZ / TICK_HZ;
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [CW-1:0] MAX_C    = CW'(MAX_COUNT);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;

  state_t        state;
  logic [DW-1:0] div_cnt;
  logic          ss_meta, ss_sync, ss_prev;
  logic          ss_rise;
  logic          tick;
  logic [CW-1:0] preset_sat;

  // start_stop is a raw button level; only its synchronized rising edge acts
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ss_meta <= 1'b0;
      ss_sync <= 1'b0;
      ss_prev <= 1'b0;
    end else begin
      ss_meta <= start_stop;
      ss_sync <= ss_meta;
      ss_prev <= ss_sync;
    end
  end

  assign ss_rise    = ss_sync & ~ss_prev;
  assign tick       = (state == RUN) && (div_cnt == DIV_LAST);
  assign preset_sat = (preset_in > MAX_C) ? MAX_C : preset_in;

  // Divider only advances while staying in RUN, so every RUN entry waits a full DIV
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      remaining     <= '0;
      running       <= 1'b0;
      expired       <= 1'b0;
      expired_pulse <= 1'b0;
      div_cnt       <= '0;
    end else begin
      expired_pulse <= 1'b0;
      if (load) begin
        remaining <= preset_sat;
        state     <= IDLE;
        running   <= 1'b0;
        expired   <= 1'b0;
        div_cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            div_cnt <= '0;
            if (ss_rise && remaining != '0) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
          RUN: begin
            if (tick) begin
              div_cnt <= '0;
              if (remaining <= CW'(1)) begin
                remaining     <= '0;
                state         <= EXPIRED;
                running       <= 1'b0;
                expired       <= 1'b1;
                expired_pulse <= 1'b1;
              end else begin
                remaining <= remaining - 1'b1;
                if (ss_rise) begin
                  state   <= PAUSE;
                  running <= 1'b0;
                end
              end
            end else if (ss_rise) begin
              div_cnt <= '0;
              state   <= PAUSE;
              running <= 1'b0;
            end else begin
              div_cnt <= div_cnt + 1'b1;
            end
          end
          PAUSE: begin
            div_cnt <= '0;
            if (ss_rise) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
          EXPIRED: begin
            div_cnt   <= '0;
            remaining <= '0;
            if (ss_rise) begin
              state   <= IDLE;
              expired <= 1'b0;
            end
          end
          default: begin
            state   <= IDLE;
            running <= 1'b0;
            expired <= 1'b0;
            div_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: stimulus queues each expected output
// change with the clock edge it must appear on; a monitor compares changes.
module tb_countdown_timer;

  localparam int CW = 14;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [CW-1:0] preset_in = '0;
  logic          load = 1'b0;
  logic          start_stop = 1'b0;
  logic [CW-1:0] remaining;
  logic          running, expired, expired_pulse;

  countdown_timer #(.CLK_FREQ_HZ(10), .TICK_HZ(1), .MAX_COUNT(9999)) dut (
    .clk(clk), .reset(reset), .preset_in(preset_in), .load(load),
    .start_stop(start_stop), .remaining(remaining), .running(running),
    .expired(expired), .expired_pulse(expired_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    int rem;
    bit run;
    bit exp;
    bit pls;
    int cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc++;

  // Monitor: every change of the output tuple must match the next queued entry
  logic [CW+2:0] last = '0;
  always @(negedge clk) begin
    logic [CW+2:0] cur;
    exp_t e;
    cur = {remaining, running, expired, expired_pulse};
    if (cur != last) begin
      n_chk++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_change cyc=%0d got rem=%0d run=%0b exp=%0b pls=%0b, none expected",
                 cyc, remaining, running, expired, expired_pulse);
      end else begin
        e = q.pop_front();
        if (int'(remaining) != e.rem || running != e.run || expired != e.exp ||
            expired_pulse != e.pls || (e.cyc >= 0 && e.cyc != cyc)) begin
          n_fail++;
          $display("FAIL output_change got rem=%0d run=%0b exp=%0b pls=%0b cyc=%0d, want rem=%0d run=%0b exp=%0b pls=%0b cyc=%0d",
                   remaining, running, expired, expired_pulse, cyc,
                   e.rem, e.run, e.exp, e.pls, e.cyc);
        end
      end
      last = cur;
    end
  end

  task automatic push(int rem, bit run, bit exp, bit pls, int c);
    exp_t e;
    e.rem = rem; e.run = run; e.exp = exp; e.pls = pls; e.cyc = c;
    q.push_back(e);
  endtask

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(string name, int act, int want);
    n_chk++;
    if (act != want) begin
      n_fail++;
      $display("FAIL %s got %0d want %0d", name, act, want);
    end
  endtask

  task automatic do_load(int v, int rem_exp);
    preset_in = CW'(v);
    load = 1'b1;
    push(rem_exp, 0, 0, 0, cyc + 1);
    step(1);
    load = 1'b0;
  endtask

  task automatic press();
    start_stop = 1'b1;
    step(4);
    start_stop = 1'b0;
    step(3);
  endtask

  int c;

  initial begin
    // 1: reset state, idle, start with zero count
    step(2);
    chk("reset_remaining", int'(remaining), 0);
    chk("reset_flags", int'({running, expired, expired_pulse}), 0);
    reset = 1'b0;
    step(50);
    chk("idle_remaining", int'(remaining), 0);
    press();
    step(5);
    chk("zero_start_running", int'(running), 0);

    // 2: load 3, run to expiry, acknowledge
    do_load(3, 3);
    step(2);
    c = cyc;
    push(3, 1, 0, 0, c + 3);
    push(2, 1, 0, 0, c + 13);
    push(1, 1, 0, 0, c + 23);
    push(0, 0, 1, 1, c + 33);
    push(0, 0, 1, 0, c + 34);
    press();
    step(40);
    c = cyc;
    push(0, 0, 0, 0, c + 3);
    press();
    step(3);

    // 3: pause after 15 cycles of RUN, hold, resume
    do_load(5, 5);
    step(2);
    c = cyc;
    push(5, 1, 0, 0, c + 3);
    push(4, 1, 0, 0, c + 13);
    press();
    step(8);
    c = cyc;
    push(4, 0, 0, 0, c + 3);
    press();
    step(100);
    chk("pause_hold", int'(remaining), 4);
    c = cyc;
    push(4, 1, 0, 0, c + 3);
    push(3, 1, 0, 0, c + 13);
    press();
    step(8);

    // 4: saturating load mid-run, then reload colliding with a tick
    do_load(12000, 9999);
    step(2);
    c = cyc;
    push(9999, 1, 0, 0, c + 3);
    press();
    step(5);
    do_load(7, 7);
    step(2);
    c = cyc;
    push(7, 1, 0, 0, c + 3);
    push(6, 1, 0, 0, c + 13);
    press();
    step(8);
    do_load(2, 2);
    step(2);

    // 5a: load on the same edge as the synced rise
    start_stop = 1'b1;
    step(2);
    preset_in = CW'(4);
    load = 1'b1;
    push(4, 0, 0, 0, cyc + 1);
    step(1);
    load = 1'b0;
    step(1);
    start_stop = 1'b0;
    step(15);
    chk("load_beats_rise_running", int'(running), 0);

    // 5b: tick and pause together at remaining=2
    do_load(2, 2);
    step(2);
    c = cyc;
    push(2, 1, 0, 0, c + 3);
    push(1, 0, 0, 0, c + 13);
    press();
    step(3);
    press();
    step(20);

    // 5c: tick and pause together at remaining=1 -> expiry wins
    c = cyc;
    push(1, 1, 0, 0, c + 3);
    push(0, 0, 1, 1, c + 13);
    push(0, 0, 1, 0, c + 14);
    press();
    step(3);
    press();
    step(10);
    c = cyc;
    push(0, 0, 0, 0, c + 3);
    press();
    step(3);

    // 6: asynchronous reset between edges mid-RUN
    do_load(5, 5);
    step(2);
    c = cyc;
    push(5, 1, 0, 0, c + 3);
    push(4, 1, 0, 0, c + 13);
    press();
    step(13);
    #2;
    push(0, 0, 0, 0, -1);
    reset = 1'b1;
    #1;
    chk("async_reset_remaining", int'(remaining), 0);
    chk("async_reset_running", int'(running), 0);
    chk("async_reset_expired", int'({expired, expired_pulse}), 0);
    @(negedge clk);
    reset = 1'b0;
    step(2);
    press();
    step(15);
    chk("post_reset_running", int'(running), 0);
    chk("post_reset_remaining", int'(remaining), 0);

    chk("scoreboard_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
Millisecond countdown timer, the down-counting counterpart of the lab stopwatch. It loads a preset value, decrements it once per tick of an internally generated tick enable, and supports pause and resume from a button-level input. It flags expiry with a held level and a one-cycle pulse. The `remaining` output is plain binary so it can feed the existing `binary_to_digits`/`digit_to_ssd`/`basys_ssd` display chain unchanged.

Parameters:
- `CLK_FREQ_HZ`, 100_000_000, frequency of `clk`.
- `TICK_HZ`, 1000, decrement rate. `DIV = CLK_FREQ_HZ/TICK_HZ`, must be ≥ 2.
- `MAX_COUNT`, 9999, largest loadable value. Derived localparam `CW = $clog2(MAX_COUNT+1)`.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `preset_in`  in  CW  value loaded on `load`.
- `load`  in  1  synchronous load strobe, one-cycle pulse, already in the `clk` domain.
- `start_stop`  in  1  asynchronous button level; each rising edge is one command.
- `remaining`  out  CW  current count, registered.
- `running`  out  1  high while in RUN, registered.
- `expired`  out  1  high while in EXPIRED, registered.
- `expired_pulse`  out  1  one-cycle pulse when the count reaches 0, registered.

Behaviour:
- Clock is `clk`. Reset is `reset`, asynchronous, active-high.
- Reset values:
  - state = IDLE; `remaining` = 0; `running`, `expired`, `expired_pulse` = 0.
  - Divider counter = 0; synchronizer and edge registers = 0.
- `start_stop` synchronization:
  - 2-FF synchronizer `ss_meta`→`ss_sync`, then `ss_prev`; `ss_rise = ss_sync & ~ss_prev`.
  - An input rise before clk edge N takes effect at edge N+2.
  - Holding the level high produces only one command.
- Tick generator:
  - Divider counts only in RUN, 0..DIV-1; `tick` is asserted when the counter is at DIV-1, and the counter wraps to 0.
  - The counter is cleared to 0 in every other state and on `load`.
  - The first decrement therefore occurs exactly DIV cycles after RUN is entered.
- State machine: IDLE, RUN, PAUSE, EXPIRED.
  - Priority within a cycle: `load` > tick > `ss_rise`.
  - `load`, any state:
    - `remaining` ← min(`preset_in`, `MAX_COUNT`) (saturating).
    - state ← IDLE; `expired` ← 0; divider ← 0.
    - Any simultaneous `ss_rise` or tick is discarded.
  - IDLE:
    - `ss_rise` with `remaining` ≠ 0 → RUN.
    - `ss_rise` with `remaining` = 0 → stay in IDLE, no expiry.
  - RUN:
    - On tick, `remaining` ← `remaining` − 1.
    - If `remaining` was 1: `remaining` ← 0, state ← EXPIRED, `expired_pulse` = 1 for exactly one cycle.
    - `ss_rise` → PAUSE.
    - Tick and `ss_rise` in the same cycle: the decrement is applied and state → PAUSE, unless the decrement reaches 0, in which case EXPIRED wins.
  - PAUSE:
    - `remaining` held; divider held at 0.
    - `ss_rise` → RUN.
  - EXPIRED:
    - `remaining` = 0, `expired` = 1.
    - `ss_rise` → IDLE, `expired` ← 0 (acknowledge).
- Output encoding: `running` = (next state == RUN) and `expired` = (next state == EXPIRED), both registered with the state, so they change on the same edge as the state.
- `remaining` never underflows, never wraps and never exceeds `MAX_COUNT`.
- Asynchronous reset mid-operation returns all outputs to their reset values immediately, without waiting for a clock edge.

Test Plan:
Parameters for the bench: `CLK_FREQ_HZ`=10, `TICK_HZ`=1 (DIV=10), `MAX_COUNT`=9999.
1. Assert `reset` → all outputs 0; release reset, idle 50 cycles → outputs unchanged; `start_stop` pulse with `remaining`=0 → stays IDLE, `running`=0, no `expired_pulse`.
2. `load` with `preset_in`=3, then `start_stop` rise → `running`=1 two edges after the synced rise.
   - `remaining` steps 3→2→1→0 at 10, 20 and 30 cycles after RUN entry.
   - `expired_pulse` high for exactly 1 cycle on the 3→0 edge sequence end; `expired`=1 and `running`=0 thereafter.
   - A further `start_stop` rise → IDLE, `expired`=0.
3. Pause/resume: `preset_in`=5, run 15 cycles → `remaining`=4.
   - Pause rise → `running`=0; `remaining` holds 4 for 100 cycles.
   - Resume → `remaining`=3 exactly 10 cycles after RUN re-entry.
4. Saturation and reload:
   - `load` with `preset_in`=12000 → `remaining`=9999.
   - Start, then `load` 7 mid-run → state IDLE, `remaining`=7, `running`=0, divider cleared (next run decrements 10 cycles after start).
5. Simultaneous events:
   - `load` in the same cycle as the synced rise → load wins, state IDLE.
   - Tick and pause rise in the same cycle with `remaining`=2 → `remaining`=1, PAUSE.
   - Same with `remaining`=1 → EXPIRED plus `expired_pulse`.
6. Assert `reset` asynchronously mid-RUN (between clk edges) → `remaining`, `running`, `expired`, `expired_pulse` go to 0 without a clock edge.
   - After release, the first `start_stop` rise in IDLE with 0 produces no RUN.
